gas_sensor_scan_controller: RTL and testbench

//  Time-shares one GasDetectorSensor among NUM_CH serial gas-sensor lines.
//  Per channel, round-robin: clear the detector, stream FRAME_BITS bits into its din,

---
 rtl/gas_sensor_pkg.sv | 22 ++
 rtl/gas_alarm_debounce.sv | 58 +++++
 rtl/gas_sensor_scan_controller.sv | 130 +++++++++++++
 tb/tb_gas_sensor_scan_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gas_sensor_pkg.sv
// Shared types and widths for the gas sensor scan controller.
// No logic, so no latency.
// No handshakes, so no backpressure.
package gas_sensor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_SETTLE,
        ST_CAPTURE
    } state_t;

    localparam int LEVEL_W = 3;
    localparam int HC_W    = 3;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gas_alarm_debounce.sv
// Per-channel alarm debounce: saturating count of consecutive high captures, latches an alarm.
// Counter and alarm update on the cycle cap_en is high; alarm_next shows the value they load.
// No backpressure; cap_en and ack are single-cycle strobes.
module gas_alarm_debounce
    import gas_sensor_pkg::*;
#(
    parameter logic [LEVEL_W-1:0] ALARM_LVL = 3'd4,
    parameter int                 ALARM_CNT = 2
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               cap_en,
    input  logic [LEVEL_W-1:0] level,
    input  logic               ack,
    output logic               alarm,
    output logic               alarm_next
);

    localparam logic [HC_W-1:0] HC_MAX = '1;
    localparam logic [HC_W-1:0] HC_TRIP = HC_W'(ALARM_CNT);

    logic [HC_W-1:0] hc;
    logic [HC_W-1:0] hc_inc;
    logic            high;
    logic            set;

    // A capture that pushes the run of highs to the trip count sets the alarm,
    // and a set on this channel beats an acknowledge arriving in the same cycle.
    always_comb begin
        high       = (level >= ALARM_LVL);
        hc_inc     = (hc == HC_MAX) ? hc : hc + 1'b1;
        set        = cap_en && high && (hc_inc >= HC_TRIP);
        alarm_next = alarm;
        if (set) begin
            alarm_next = 1'b1;
        end else if (ack) begin
            alarm_next = 1'b0;
        end
    end

    // Run counter and latched alarm; acknowledge restarts the run unless this channel just tripped.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            hc    <= '0;
            alarm <= 1'b0;
        end else begin
            alarm <= alarm_next;
            if (set) begin
                hc <= hc_inc;
            end else if (ack) begin
                hc <= '0;
            end else if (cap_en) begin
                hc <= high ? hc_inc : '0;
            end
        end
    end

endmodule

// File: rtl/gas_sensor_scan_controller.sv
// Round-robin scanner sharing one gas detector across NUM_CH serial sensor lines.
// FRAME_BITS+SETTLE+2 cycles per channel; every output is registered.
// No backpressure; enable low lets the current channel finish, then the scan parks in IDLE.
module gas_sensor_scan_controller
    import gas_sensor_pkg::*;
#(
    parameter int                 NUM_CH     = 4,
    parameter int                 FRAME_BITS = 8,
    parameter int                 SETTLE     = 1,
    parameter logic [LEVEL_W-1:0] ALARM_LVL  = 3'd4,
    parameter int                 ALARM_CNT  = 2
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        enable,
    input  logic [NUM_CH-1:0]           ch_din,
    input  logic                        ack_alarm,
    output logic                        det_rst,
    output logic                        det_din,
    input  logic [LEVEL_W-1:0]          det_dout,
    output logic [ch_w(NUM_CH)-1:0]     cur_ch,
    output logic [LEVEL_W*NUM_CH-1:0]   level_flat,
    output logic [NUM_CH-1:0]           level_valid,
    output logic                        scan_done,
    output logic [NUM_CH-1:0]           alarm,
    output logic                        alarm_any
);

    localparam int CW      = ch_w(NUM_CH);
    localparam int CNT_MAX = (FRAME_BITS > SETTLE) ? FRAME_BITS : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FEED_LAST   = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [CW-1:0]    CH_LAST     = CW'(NUM_CH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              cap_en;
    logic [NUM_CH-1:0] alarm_nxt;

    // Next-state sequencing; the counter times both the frame and the settle gap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_FEED;
                cnt_nxt   = '0;
            end
            ST_FEED: begin
                if (cnt == FEED_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_CAPTURE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_CAPTURE: begin
                cap_en    = 1'b1;
                state_nxt = enable ? ST_CLEAR : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, detector drive, channel pointer and captured levels.
    // det_rst follows the state being entered so it drops exactly when FEED starts;
    // det_din carries the selected line one cycle late.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cur_ch      <= '0;
            det_rst     <= 1'b1;
            det_din     <= 1'b0;
            scan_done   <= 1'b0;
            level_flat  <= '0;
            level_valid <= '0;
            alarm_any   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            det_rst   <= (state_nxt == ST_IDLE) || (state_nxt == ST_CLEAR);
            det_din   <= (state == ST_FEED) ? ch_din[cur_ch] : 1'b0;
            scan_done <= cap_en && (cur_ch == CH_LAST);
            alarm_any <= |alarm_nxt;
            if (cap_en) begin
                level_flat[cur_ch*LEVEL_W +: LEVEL_W] <= det_dout;
                level_valid[cur_ch]                   <= 1'b1;
                cur_ch <= (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        gas_alarm_debounce #(
            .ALARM_LVL (ALARM_LVL),
            .ALARM_CNT (ALARM_CNT)
        ) u_debounce (
            .clk        (clk),
            .arst       (arst),
            .cap_en     (cap_en && (cur_ch == CW'(k))),
            .level      (det_dout),
            .ack        (ack_alarm),
            .alarm      (alarm[k]),
            .alarm_next (alarm_nxt[k])
        );
    end

endmodule

// File: tb/tb_gas_sensor_scan_controller.sv
module tb_gas_sensor_scan_controller;

    localparam int NUM_CH = 4;
    localparam int FB     = 8;

    typedef struct {
        int         ch;
        logic [11:0] lf;
        logic [3:0]  lv;
        logic [3:0]  al;
        logic        any;
        logic        done;
    } exp_t;

    logic        clk;
    logic        arst;
    logic        enable;
    logic [3:0]  ch_din;
    logic        ack_alarm;
    logic        det_rst;
    logic        det_din;
    logic [2:0]  det_dout;
    logic [1:0]  cur_ch;
    logic [11:0] level_flat;
    logic [3:0]  level_valid;
    logic        scan_done;
    logic [3:0]  alarm;
    logic        alarm_any;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    logic [2:0] lvl   [NUM_CH];
    logic [2:0] m_lvl [NUM_CH];
    int         m_hc  [NUM_CH];
    logic [3:0] m_al;
    logic [3:0] m_val;

    gas_sensor_scan_controller #(
        .NUM_CH(4), .FRAME_BITS(8), .SETTLE(1), .ALARM_LVL(3'd4), .ALARM_CNT(2)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .enable      (enable),
        .ch_din      (ch_din),
        .ack_alarm   (ack_alarm),
        .det_rst     (det_rst),
        .det_din     (det_din),
        .det_dout    (det_dout),
        .cur_ch      (cur_ch),
        .level_flat  (level_flat),
        .level_valid (level_valid),
        .scan_done   (scan_done),
        .alarm       (alarm),
        .alarm_any   (alarm_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Random serial data on every sensor line, changed well away from both edges.
    initial begin
        ch_din = '0;
        forever begin
            @(posedge clk);
            #2;
            ch_din = 4'($urandom);
        end
    end

    // Behavioural detector: after FB clocked bits out of reset it presents the programmed level.
    int dcnt = 0;
    initial begin
        det_dout = '0;
        forever begin
            @(negedge clk);
            if (det_rst) begin
                dcnt     = 0;
                det_dout = '0;
            end else begin
                dcnt++;
                if (dcnt == FB) det_dout = lvl[cur_ch];
            end
        end
    end

    // det_din must repeat the serviced line one cycle late during each frame.
    int   run = 0;
    logic pf  = 1'b0;
    logic pb  = 1'b0;
    always @(negedge clk) begin
        if (arst) begin
            run = 0;
            pf  = 1'b0;
        end else begin
            if (pf) check("det_din", {31'd0, det_din}, {31'd0, pb});
            pf = !det_rst && (run < FB);
            pb = ch_din[cur_ch];
            if (det_rst) run = 0;
            else run++;
        end
    end

    // Scoreboard monitor: a channel advance marks a capture; compare against the queued result.
    logic [1:0] prev_ch = '0;
    always @(negedge clk) begin
        exp_t e;
        if (arst) begin
            prev_ch = cur_ch;
        end else begin
            if (cur_ch != prev_ch) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_capture: ch %0d captured, none queued", prev_ch);
                end else begin
                    e = q.pop_front();
                    check("cap_ch",      {30'd0, prev_ch},     e.ch);
                    check("level_flat",  {20'd0, level_flat},  {20'd0, e.lf});
                    check("level_valid", {28'd0, level_valid}, {28'd0, e.lv});
                    check("alarm",       {28'd0, alarm},       {28'd0, e.al});
                    check("alarm_any",   {31'd0, alarm_any},   {31'd0, e.any});
                    check("scan_done",   {31'd0, scan_done},   {31'd0, e.done});
                end
            end else if (scan_done) begin
                checks++;
                errors++;
                $display("FAIL stray_scan_done: scan_done=1 without capture");
            end
            prev_ch = cur_ch;
        end
    end

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_lvl[k] = '0;
            m_hc[k]  = 0;
        end
        m_al  = '0;
        m_val = '0;
    endtask

    task automatic model_ack();
        for (int k = 0; k < NUM_CH; k++) m_hc[k] = 0;
        m_al = '0;
    endtask

    // Queue the expected results for captures first..last; ack_ch marks a capture coinciding with ack.
    task automatic push_scan(input int first, input int last, input int ack_ch);
        exp_t e;
        logic high;
        logic set;
        for (int k = first; k <= last; k++) begin
            m_lvl[k] = lvl[k];
            m_val[k] = 1'b1;
            high = (lvl[k] >= 3'd4);
            if (high) m_hc[k] = (m_hc[k] == 7) ? 7 : m_hc[k] + 1;
            else m_hc[k] = 0;
            set = high && (m_hc[k] >= 2);
            if (k == ack_ch) begin
                for (int j = 0; j < NUM_CH; j++) begin
                    if (j != k) begin
                        m_al[j] = 1'b0;
                        m_hc[j] = 0;
                    end
                end
                if (!set) begin
                    m_al[k] = 1'b0;
                    m_hc[k] = 0;
                end
            end
            if (set) m_al[k] = 1'b1;
            e.ch = k;
            for (int j = 0; j < NUM_CH; j++) e.lf[j*3 +: 3] = m_lvl[j];
            e.lv   = m_val;
            e.al   = m_al;
            e.any  = |m_al;
            e.done = (k == NUM_CH - 1);
            q.push_back(e);
        end
    endtask

    task automatic set_lvl(input logic [2:0] l0, input logic [2:0] l1,
                           input logic [2:0] l2, input logic [2:0] l3);
        lvl[0] = l0; lvl[1] = l1; lvl[2] = l2; lvl[3] = l3;
    endtask

    // Advance to the next scan_done, bounded; returns the number of cycles waited.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scan_done && n < 200);
        if (!scan_done) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: no scan_done within %0d cycles", n);
        end
    endtask

    task automatic ack_now();
        ack_alarm = 1'b1;
        model_ack();
    endtask

    int n;

    initial begin
        arst      = 1'b1;
        enable    = 1'b0;
        ack_alarm = 1'b0;
        set_lvl(0, 0, 0, 0);
        model_reset();

        // 1. reset and idle with enable low
        #20;
        check("rst_det_rst", {31'd0, det_rst}, 32'd1);
        check("rst_outputs", {cur_ch, level_flat, level_valid, scan_done, alarm, alarm_any, det_din}, '0);
        #22;
        arst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_det_rst", {31'd0, det_rst}, 32'd1);
            check("idle_outputs", {cur_ch, level_flat, level_valid, scan_done, alarm, alarm_any, det_din}, '0);
        end

        // 2. two scans of {1,2,3,5}; 44-cycle scan period
        set_lvl(1, 2, 3, 5);
        push_scan(0, 3, -1);
        enable = 1'b1;
        wait_done(n);
        check("scan1_level_flat", {20'd0, level_flat}, {20'd0, 12'b101_011_010_001});
        check("scan1_level_valid", {28'd0, level_valid}, 32'hF);
        push_scan(0, 3, -1);
        wait_done(n);
        check("scan_period", n, 44);
        check("scan2_alarm", {28'd0, alarm}, 32'b1000);

        // 3. ch2 high twice, then low; alarm holds until acknowledged
        ack_now();
        set_lvl(0, 0, 5, 0);
        push_scan(0, 3, -1);
        @(negedge clk);
        ack_alarm = 1'b0;
        check("ack_clears", {27'd0, alarm, alarm_any}, 32'd0);
        wait_done(n);
        push_scan(0, 3, -1);
        wait_done(n);
        check("ch2_alarm", {27'd0, alarm, alarm_any}, {27'd0, 4'b0100, 1'b1});
        set_lvl(0, 0, 0, 0);
        push_scan(0, 3, -1);
        wait_done(n);
        check("ch2_alarm_held", {28'd0, alarm}, 32'b0100);
        ack_now();
        set_lvl(0, 6, 0, 4);
        push_scan(0, 3, -1);
        @(negedge clk);
        ack_alarm = 1'b0;
        check("ack2_clears", {27'd0, alarm, alarm_any}, 32'd0);
        wait_done(n);

        // 4. ch1 high/low/high never trips; ack coinciding with the ch3 set keeps ch3 only
        set_lvl(0, 1, 0, 0);
        push_scan(0, 3, -1);
        wait_done(n);
        set_lvl(4, 7, 0, 4);
        push_scan(0, 3, -1);
        wait_done(n);
        check("nonconsec_no_alarm", {28'd0, alarm}, 32'd0);
        set_lvl(4, 0, 0, 4);
        push_scan(0, 3, 3);
        repeat (43) @(negedge clk);
        ack_alarm = 1'b1;
        @(negedge clk);
        ack_alarm = 1'b0;
        check("ack_vs_set_done", {31'd0, scan_done}, 32'd1);
        check("ack_vs_set_alarm", {28'd0, alarm}, 32'b1000);

        // 5. enable dropped during ch1 frame; ch1 completes, scan parks at ch2, then resumes
        set_lvl(2, 3, 1, 6);
        push_scan(0, 1, -1);
        repeat (14) @(negedge clk);
        enable = 1'b0;
        repeat (15) @(negedge clk);
        check("park_cur_ch", {30'd0, cur_ch}, 32'd2);
        check("park_det_rst", {31'd0, det_rst}, 32'd1);
        check("park_valid", {28'd0, level_valid}, 32'hF);
        check("park_queue", q.size(), 0);
        push_scan(2, 3, -1);
        enable = 1'b1;
        wait_done(n);
        check("resume_alarm", {28'd0, alarm}, 32'b1000);

        // 6. reset pulse during ch3 frame: immediate reset values, restart at ch0
        set_lvl(3, 4, 2, 7);
        push_scan(0, 2, -1);
        repeat (36) @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("arst_det_rst", {31'd0, det_rst}, 32'd1);
        check("arst_outputs", {cur_ch, level_flat, level_valid, scan_done, alarm, alarm_any, det_din}, '0);
        check("arst_queue", q.size(), 0);
        model_reset();
        repeat (2) @(negedge clk);
        #2;
        arst = 1'b0;
        push_scan(0, 3, -1);
        wait_done(n);
        check("restart_level_flat", {20'd0, level_flat}, {20'd0, 12'b111_010_100_011});
        check("restart_alarm", {28'd0, alarm}, 32'd0);

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
